// File: rtl/minterm_pkg.sv
// Shared types and helpers for the minterm stream classifier.
package minterm_pkg;

    localparam int MAX_W = 8;

    // 4-input exercise: on-set {2,7,15}, don't-care set {3,8,11,12}
    localparam logic [15:0] DEF_ONSET = 16'h8084;
    localparam logic [15:0] DEF_DCSET = 16'h1908;

    typedef struct packed {
        logic             sop;
        logic             pos;
        logic             dc;
        logic [MAX_W-1:0] data;
    } mt_res_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [32:0] max_v;
        max_v = (33'd1 << w) - 33'd1;
        if ({1'b0, v} >= max_v) return v;
        return v + 32'd1;
    endfunction

endpackage

// File: rtl/minterm_lut.sv
// Combinational minterm lookup: vector -> SOP/POS/don't-care result.
module minterm_lut
    import minterm_pkg::*;
#(
    parameter int                    WIDTH = 4,
    parameter logic [(1<<WIDTH)-1:0] ONSET = DEF_ONSET,
    parameter logic [(1<<WIDTH)-1:0] DCSET = DEF_DCSET
) (
    input  logic [WIDTH-1:0] vec_i,
    output mt_res_t          res_o
);

    if (WIDTH < 1 || WIDTH > MAX_W || (ONSET & DCSET) != '0) begin : g_bad_params
        $fatal(1, "minterm_lut: illegal WIDTH or overlapping ONSET/DCSET");
    end

    logic on, dc;
    assign on = ONSET[vec_i];
    assign dc = DCSET[vec_i];

    always_comb begin
        res_o                  = '0;
        res_o.sop              = on & ~dc;
        res_o.pos              = on | dc;
        res_o.dc               = dc;
        res_o.data[WIDTH-1:0]  = vec_i;
    end

endmodule

// File: rtl/minterm_stream_classifier.sv
// Two-stage valid/ready classifier with saturating hit and don't-care counters.
module minterm_stream_classifier
    import minterm_pkg::*;
#(
    parameter int                    WIDTH = 4,
    parameter logic [(1<<WIDTH)-1:0] ONSET = DEF_ONSET,
    parameter logic [(1<<WIDTH)-1:0] DCSET = DEF_DCSET,
    parameter int                    CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sop,
    output logic             out_pos,
    output logic             out_dc,
    output logic [WIDTH-1:0] out_data,
    input  logic             clr_counts,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] dc_count
);

    logic             s1_v_q, s2_v_q;
    logic [WIDTH-1:0] s1_data_q;
    mt_res_t          res_q, lut_res;
    logic [CNT_W-1:0] hit_q, hit_d, dc_q, dc_d;
    logic [31:0]      hit_inc, dc_inc;
    logic             s1_load, s2_load, in_fire, out_fire;
    logic             unused_bits;

    minterm_lut #(.WIDTH(WIDTH), .ONSET(ONSET), .DCSET(DCSET)) u_lut (
        .vec_i (s1_data_q),
        .res_o (lut_res)
    );

    // Ready ripples back combinationally so a full pipe still streams at 1/cycle
    assign s2_load  = !s2_v_q || out_ready;
    assign s1_load  = !s1_v_q || s2_load;
    assign in_ready = !reset && s1_load;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_v_q && out_ready;

    always_comb begin
        hit_inc = sat_inc(32'(hit_q), CNT_W);
        dc_inc  = sat_inc(32'(dc_q), CNT_W);
        hit_d   = hit_q;
        dc_d    = dc_q;
        if (clr_counts) begin
            hit_d = '0;
            dc_d  = '0;
        end else if (out_fire) begin
            if (res_q.sop) hit_d = hit_inc[CNT_W-1:0];
            if (res_q.dc)  dc_d  = dc_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s1_data_q <= '0;
            res_q     <= '0;
            hit_q     <= '0;
            dc_q      <= '0;
        end else begin
            if (s1_load) s1_v_q <= in_fire;
            if (in_fire) s1_data_q <= in_data;
            if (s2_load) s2_v_q <= s1_v_q;
            if (s2_load && s1_v_q) res_q <= lut_res;
            hit_q <= hit_d;
            dc_q  <= dc_d;
        end
    end

    assign out_valid   = s2_v_q;
    assign out_sop     = res_q.sop;
    assign out_pos     = res_q.pos;
    assign out_dc      = res_q.dc;
    assign out_data    = res_q.data[WIDTH-1:0];
    assign hit_count   = hit_q;
    assign dc_count    = dc_q;
    assign unused_bits = ^{res_q.data, hit_inc, dc_inc};

endmodule

// File: tb/tb_minterm_stream_classifier.sv
// Randomized scoreboard bench for minterm_stream_classifier (default, CNT_W=2 and WIDTH=3 instances).
module tb_minterm_stream_classifier;

    localparam logic [15:0] ON4 = 16'h8084;
    localparam logic [15:0] DC4 = 16'h1908;
    localparam logic [15:0] ON3 = 16'h0081;
    localparam logic [15:0] DC3 = 16'h0002;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // default instance
    logic       in_valid, in_ready, out_valid, out_ready, out_sop, out_pos, out_dc, clr_counts;
    logic [3:0] in_data, out_data;
    logic [7:0] hit_count, dc_count;
    // CNT_W=2 instance
    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_sop, s_pos, s_dc, s_clr;
    logic [3:0] s_in_data, s_out_data;
    logic [1:0] s_hit, s_dcc;
    // WIDTH=3 instance
    logic       w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_sop, w_pos, w_dc, w_clr;
    logic [2:0] w_in_data, w_out_data;
    logic [7:0] w_hit, w_dcc;

    minterm_stream_classifier u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_pos(out_pos),
        .out_dc(out_dc), .out_data(out_data), .clr_counts(clr_counts),
        .hit_count(hit_count), .dc_count(dc_count));

    minterm_stream_classifier #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sop(s_sop), .out_pos(s_pos),
        .out_dc(s_dc), .out_data(s_out_data), .clr_counts(s_clr),
        .hit_count(s_hit), .dc_count(s_dcc));

    minterm_stream_classifier #(.WIDTH(3), .ONSET(8'h81), .DCSET(8'h02)) u_w3 (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_sop(w_sop), .out_pos(w_pos),
        .out_dc(w_dc), .out_data(w_out_data), .clr_counts(w_clr),
        .hit_count(w_hit), .dc_count(w_dcc));

    int checks   = 0;
    int failures = 0;

    // scoreboard / model state for u_dut
    logic [3:0]  sb[$];
    logic [3:0]  seen[$];
    int unsigned m_hit = 0, m_dc = 0;
    logic        stall_pend = 1'b0;
    logic [6:0]  stall_snap;

    // {sop, pos, dc} from the set definitions
    function automatic logic [2:0] cls(input logic [15:0] on_m, input logic [15:0] dc_m, input int v);
        logic on, dc;
        on = on_m[v];
        dc = dc_m[v];
        return {on & ~dc, on | dc, dc};
    endfunction

    // one cycle on u_dut: drive, sample at negedge, score transfers, return at posedge+1
    task automatic step(input logic iv, input logic [3:0] d, input logic ordy, output logic acc);
        logic [3:0] e;
        logic [2:0] x;
        in_valid = iv; in_data = d; out_ready = ordy;
        @(negedge clk);
        if (stall_pend) begin
            checks++;
            if (out_valid !== 1'b1 || {out_sop, out_pos, out_dc, out_data} !== stall_snap) begin
                failures++;
                $display("FAIL stall_hold got v=%b %b req %b", out_valid,
                         {out_sop, out_pos, out_dc, out_data}, stall_snap);
            end
        end
        checks++;
        if (hit_count !== 8'(m_hit) || dc_count !== 8'(m_dc)) begin
            failures++;
            $display("FAIL counters got hit=%0d dc=%0d req hit=%0d dc=%0d", hit_count, dc_count, m_hit, m_dc);
        end
        if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL spurious_output got data=%0d req none", out_data);
            end else begin
                e = sb.pop_front();
                x = cls(ON4, DC4, int'(e));
                if ({out_sop, out_pos, out_dc, out_data} !== {x, e}) begin
                    failures++;
                    $display("FAIL sb_fields got sop=%b pos=%b dc=%b data=%0d req %b data=%0d",
                             out_sop, out_pos, out_dc, out_data, x, e);
                end
                if (x[2]) m_hit = (m_hit < 255) ? m_hit + 1 : m_hit;
                if (x[0]) m_dc  = (m_dc  < 255) ? m_dc  + 1 : m_dc;
            end
            seen.push_back(out_data);
        end
        acc = in_valid && in_ready;
        if (acc) sb.push_back(d);
        stall_pend = out_valid && !out_ready;
        stall_snap = {out_sop, out_pos, out_dc, out_data};
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 0; in_data = 0; out_ready = 1; clr_counts = 0;
        s_in_valid = 0; s_in_data = 0; s_out_ready = 1; s_clr = 0;
        w_in_valid = 0; w_in_data = 0; w_out_ready = 1; w_clr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_sop, out_pos, out_dc, out_data, hit_count, dc_count} !== '0) begin
            failures++;
            $display("FAIL reset_state got rdy=%b v=%b sop=%b pos=%b dc=%b data=%0d hit=%0d dcc=%0d req all 0",
                     in_ready, out_valid, out_sop, out_pos, out_dc, out_data, hit_count, dc_count);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got rdy=%b v=%b req rdy=1 v=0", in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_truth_table();
        logic a;
        seen.delete();
        for (int v = 0; v < 16; v++) begin
            step(1'b1, 4'(v), 1'b1, a);
            checks++;
            if (a !== 1'b1) begin
                failures++;
                $display("FAIL stream_accept got %b req 1 for v=%0d", a, v);
            end
        end
        repeat (4) step(1'b0, 4'd0, 1'b1, a);
        checks++;
        if (hit_count !== 8'd3 || dc_count !== 8'd4 || seen.size() != 16) begin
            failures++;
            $display("FAIL truth_totals got hit=%0d dc=%0d n=%0d req hit=3 dc=4 n=16",
                     hit_count, dc_count, seen.size());
        end
    endtask

    task automatic test_backpressure();
        logic a;
        int   k;
        seen.delete();
        step(1'b1, 4'd2, 1'b0, a);
        step(1'b1, 4'd7, 1'b0, a);
        in_valid = 1'b1; in_data = 4'd9; out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_full got rdy=%b v=%b req rdy=0 v=1", in_ready, out_valid);
        end
        repeat (3) begin
            step(1'b1, 4'd9, 1'b0, a);
            checks++;
            if (a !== 1'b0) begin
                failures++;
                $display("FAIL bp_stall got accept=%b req 0", a);
            end
        end
        k = 0;
        a = 1'b0;
        while (!a && k < 20) begin
            step(1'b1, 4'd9, 1'b1, a);
            k++;
        end
        repeat (4) step(1'b0, 4'd0, 1'b1, a);
        checks++;
        if (seen.size() != 3 || seen[0] !== 4'd2 || seen[1] !== 4'd7 || seen[2] !== 4'd9) begin
            failures++;
            $display("FAIL bp_order got n=%0d req 2,7,9", seen.size());
        end
    endtask

    task automatic test_random();
        logic a;
        int   acc = 0, cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 6), a);
            if (a) acc++;
            cyc++;
        end
        repeat (4) step(1'b0, 4'd0, 1'b1, a);
        checks++;
        if (acc != 1000 || sb.size() != 0) begin
            failures++;
            $display("FAIL random_drain got acc=%0d left=%0d req acc=1000 left=0", acc, sb.size());
        end
    endtask

    task automatic test_saturation();
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1; s_in_data = 4'd15;
        repeat (5) begin @(posedge clk); #1; end
        s_in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (s_hit !== 2'd3 || s_dcc !== 2'd0) begin
            failures++;
            $display("FAIL sat_hit got hit=%0d dc=%0d req hit=3 dc=0", s_hit, s_dcc);
        end
        s_in_valid = 1'b1; s_in_data = 4'd7;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== 4'd7 || s_sop !== 1'b1) begin
            failures++;
            $display("FAIL sat_seven got v=%b data=%0d sop=%b req v=1 data=7 sop=1", s_out_valid, s_out_data, s_sop);
        end
        s_clr = 1'b1;
        @(posedge clk); #1;
        s_clr = 1'b0;
        checks++;
        if (s_hit !== 2'd0 || s_dcc !== 2'd0) begin
            failures++;
            $display("FAIL clr_wins got hit=%0d dc=%0d req 0 0", s_hit, s_dcc);
        end
    endtask

    task automatic test_width3();
        logic [2:0] res[8];
        logic [7:0] got;
        logic [2:0] x;
        got = '0;
        w_out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            w_in_valid = (c < 8);
            w_in_data  = 3'(c);
            @(negedge clk);
            if (w_out_valid) begin
                res[w_out_data] = {w_sop, w_pos, w_dc};
                got[w_out_data] = 1'b1;
            end
            @(posedge clk); #1;
        end
        w_in_valid = 1'b0;
        checks++;
        if (got !== 8'hFF) begin
            failures++;
            $display("FAIL w3_coverage got %b req 11111111", got);
        end
        for (int v = 0; v < 8; v++) begin
            x = cls(ON3, DC3, v);
            checks++;
            if (res[v] !== x) begin
                failures++;
                $display("FAIL w3_class v=%0d got %b req %b", v, res[v], x);
            end
        end
        checks++;
        if (res[0] !== 3'b110 || res[1] !== 3'b011 || res[5] !== 3'b000) begin
            failures++;
            $display("FAIL w3_points got %b %b %b req 110 011 000", res[0], res[1], res[5]);
        end
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1; in_data = 4'd5; out_ready = 1'b0;
        @(posedge clk); #1;
        in_data = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_full got rdy=%b v=%b req rdy=0 v=1", in_ready, out_valid);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || hit_count !== 8'd0 || dc_count !== 8'd0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got v=%b hit=%0d dc=%0d rdy=%b req 0 0 0 0", out_valid, hit_count, dc_count, in_ready);
        end
        reset = 1'b0;
        in_valid = 1'b1; in_data = 4'd7; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_ready got %b req 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_latency_early got v=%b req 0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_sop !== 1'b1 || out_data !== 4'd7) begin
            failures++;
            $display("FAIL mid_first got v=%b sop=%b data=%0d req v=1 sop=1 data=7", out_valid, out_sop, out_data);
        end
        sb.delete();
        m_hit = 0; m_dc = 0; stall_pend = 1'b0;
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_backpressure();
        test_random();
        test_saturation();
        test_width3();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
